// File: rtl/address_map_table.sv
// Runtime-programmable SNES address mapper: shadow/active descriptor tables with atomic commit,
// and a two-stage priority match / translate pipeline feeding the SRAM0 request mux.
module address_map_table #(
    parameter int ADDR_W      = 24,
    parameter int NUM_REGIONS = 8,
    parameter int IDX_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic              addr_valid,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [2:0]        cfg_field,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              cfg_commit,
    output logic              cfg_pending,
    output logic              out_valid,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_hit,
    output logic              is_saveram,
    output logic              is_writable,
    output logic [IDX_W-1:0]  region_idx
);

    // flags: [0] enable, [1] writable, [2] saveram, [3] fold_a15
    typedef struct packed {
        logic [3:0]        flags;
        logic [ADDR_W-1:0] xlat_base;
        logic [ADDR_W-1:0] xlat_mask;
        logic [ADDR_W-1:0] match_mask;
        logic [ADDR_W-1:0] match_val;
    } entry_t;

    entry_t shadow     [NUM_REGIONS];
    entry_t shadow_nxt [NUM_REGIONS];
    entry_t active     [NUM_REGIONS];
    logic   wr_ok;

    always_comb begin
        shadow_nxt = shadow;
        wr_ok      = cfg_we && (int'(cfg_idx) < NUM_REGIONS) && (cfg_field <= 3'd4);
        if (wr_ok) begin
            case (cfg_field)
                3'd0:    shadow_nxt[cfg_idx].match_val  = cfg_data;
                3'd1:    shadow_nxt[cfg_idx].match_mask = cfg_data;
                3'd2:    shadow_nxt[cfg_idx].xlat_mask  = cfg_data;
                3'd3:    shadow_nxt[cfg_idx].xlat_base  = cfg_data;
                default: shadow_nxt[cfg_idx].flags      = cfg_data[3:0];
            endcase
        end
    end

    // Commit copies shadow_nxt so a same-cycle write is part of the new active table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            cfg_pending <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            if (cfg_commit) begin
                active      <= shadow_nxt;
                cfg_pending <= 1'b0;
            end else if (wr_ok) begin
                cfg_pending <= 1'b1;
            end
        end
    end

    logic             hit;
    logic [IDX_W-1:0] win_idx;

    // Scan from the top so the lowest matching index is the last to assign.
    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (active[i].flags[0] &&
                (((snes_addr ^ active[i].match_val) & active[i].match_mask) == '0)) begin
                hit     = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [IDX_W-1:0]  s1_idx;
    logic [ADDR_W-1:0] s1_base;
    logic [ADDR_W-1:0] s1_mask;
    logic [3:0]        s1_flags;

    // s1_flags[0] doubles as the hit bit: a winning region is always enabled, a miss loads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_idx   <= '0;
            s1_base  <= '0;
            s1_mask  <= '0;
            s1_flags <= '0;
        end else begin
            s1_valid <= addr_valid;
            if (addr_valid) begin
                s1_addr  <= snes_addr;
                s1_idx   <= hit ? win_idx : '0;
                s1_base  <= hit ? active[win_idx].xlat_base : '0;
                s1_mask  <= hit ? active[win_idx].xlat_mask : '0;
                s1_flags <= hit ? active[win_idx].flags : '0;
            end
        end
    end

    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] xlat;

    always_comb begin
        src  = s1_flags[3] ? {1'b0, s1_addr[ADDR_W-1:16], s1_addr[14:0]} : s1_addr;
        xlat = s1_flags[0] ? (s1_base | (src & s1_mask)) : s1_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            rom_addr    <= '0;
            rom_hit     <= 1'b0;
            is_saveram  <= 1'b0;
            is_writable <= 1'b0;
            region_idx  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                rom_addr    <= xlat;
                rom_hit     <= s1_flags[0];
                is_saveram  <= s1_flags[2];
                is_writable <= s1_flags[1];
                region_idx  <= s1_idx;
            end
        end
    end

endmodule

// File: tb/tb_address_map_table.sv
// Bench for address_map_table: table-level model checked every cycle plus directed
// scenarios with hand-computed expected translations.
module tb_address_map_table;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] snes_addr = '0;
    logic        addr_valid = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [2:0]  cfg_field = '0;
    logic [23:0] cfg_data = '0;
    logic        cfg_commit = 1'b0;
    logic        cfg_pending;
    logic        out_valid;
    logic [23:0] rom_addr;
    logic        rom_hit;
    logic        is_saveram;
    logic        is_writable;
    logic [2:0]  region_idx;

    address_map_table #(.ADDR_W(24), .NUM_REGIONS(8), .IDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .snes_addr(snes_addr), .addr_valid(addr_valid),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .out_valid(out_valid),
        .rom_addr(rom_addr), .rom_hit(rom_hit), .is_saveram(is_saveram),
        .is_writable(is_writable), .region_idx(region_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit en_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [23:0] mv, mm, xm, xb;
        logic [3:0]  fl;
    } ent_t;

    typedef struct packed {
        logic [23:0] rom;
        logic        hit, sav, wr;
        logic [2:0]  idx;
    } res_t;

    ent_t m_shadow [8];
    ent_t m_active [8];
    bit   m_pend;
    bit   p1_v, mo_v;
    res_t p1, mo;

    function automatic res_t lookup(input logic [23:0] a);
        res_t r;
        logic [23:0] s;
        r = '0;
        r.rom = a;
        for (int i = 0; i < 8; i++) begin
            if (m_active[i].fl[0] && (((a ^ m_active[i].mv) & m_active[i].mm) == 24'd0)) begin
                s = m_active[i].fl[3] ? (((a >> 16) << 15) | (a & 24'h007FFF)) : a;
                r.rom = m_active[i].xb | (s & m_active[i].xm);
                r.hit = 1'b1;
                r.sav = m_active[i].fl[2];
                r.wr  = m_active[i].fl[1];
                r.idx = 3'(i);
                return r;
            end
        end
        return r;
    endfunction

    // Lookup result is taken against the table as it stood before this edge's config update.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_pend = 1'b0;
            p1_v = 1'b0; p1 = '0;
            mo_v = 1'b0; mo = '0;
        end else begin
            mo_v = p1_v;
            if (p1_v) mo = p1;
            p1_v = addr_valid;
            if (addr_valid) p1 = lookup(snes_addr);
            if (cfg_we && cfg_field <= 3'd4) begin
                case (cfg_field)
                    3'd0: m_shadow[cfg_idx].mv = cfg_data;
                    3'd1: m_shadow[cfg_idx].mm = cfg_data;
                    3'd2: m_shadow[cfg_idx].xm = cfg_data;
                    3'd3: m_shadow[cfg_idx].xb = cfg_data;
                    default: m_shadow[cfg_idx].fl = cfg_data[3:0];
                endcase
                m_pend = 1'b1;
            end
            if (cfg_commit) begin
                for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
                m_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("m_out_valid", 32'(out_valid), 32'(mo_v));
            chk("m_rom_addr", 32'(rom_addr), 32'(mo.rom));
            chk("m_rom_hit", 32'(rom_hit), 32'(mo.hit));
            chk("m_is_saveram", 32'(is_saveram), 32'(mo.sav));
            chk("m_is_writable", 32'(is_writable), 32'(mo.wr));
            chk("m_region_idx", 32'(region_idx), 32'(mo.idx));
            chk("m_cfg_pending", 32'(cfg_pending), 32'(m_pend));
        end
    end

    task automatic cfg_wr(input logic [2:0] idx, input logic [2:0] f, input logic [23:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_field = f; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_commit = 1'b0;
    endtask

    task automatic region(input logic [2:0] idx, input logic [23:0] mv, input logic [23:0] mm,
                          input logic [23:0] xm, input logic [23:0] xb, input logic [3:0] fl);
        cfg_wr(idx, 3'd0, mv);
        cfg_wr(idx, 3'd1, mm);
        cfg_wr(idx, 3'd2, xm);
        cfg_wr(idx, 3'd3, xb);
        cfg_wr(idx, 3'd4, {20'd0, fl});
    endtask

    task automatic look(input string name, input logic [23:0] a, input logic [23:0] e_rom,
                        input logic e_hit, input logic [2:0] e_idx, input logic e_sav, input logic e_wr);
        @(negedge clk);
        addr_valid = 1'b1; snes_addr = a;
        @(negedge clk);
        addr_valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_rom"}, 32'(rom_addr), 32'(e_rom));
        chk({name, "_hit"}, 32'(rom_hit), 32'(e_hit));
        chk({name, "_idx"}, 32'(region_idx), 32'(e_idx));
        chk({name, "_sav"}, 32'(is_saveram), 32'(e_sav));
        chk({name, "_wr"}, 32'(is_writable), 32'(e_wr));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_rom", 32'(rom_addr), 32'd0);
        chk("rst_hit", 32'(rom_hit), 32'd0);
        chk("rst_pending", 32'(cfg_pending), 32'd0);
        rst_n = 1'b1;
        en_cmp = 1'b1;

        cfg_wr(3'd0, 3'd5, 24'hFFFFFF);
        chk("ignored_field_pending", 32'(cfg_pending), 32'd0);
        commit();
        look("empty", 24'h018123, 24'h018123, 1'b0, 3'd0, 1'b0, 1'b0);

        region(3'd0, 24'h008000, 24'hC08000, 24'h1FFFFF, 24'h000000, 4'h9);
        chk("lorom_pending", 32'(cfg_pending), 32'd1);
        look("pre_commit", 24'h018123, 24'h018123, 1'b0, 3'd0, 1'b0, 1'b0);
        commit();
        chk("lorom_pending_clr", 32'(cfg_pending), 32'd0);
        look("lorom", 24'h018123, 24'h008123, 1'b1, 3'd0, 1'b0, 1'b0);

        region(3'd1, 24'h780000, 24'hFE0000, 24'h01FFFF, 24'hE00000, 4'h7);
        commit();
        look("saveram", 24'h79ABCD, 24'hE1ABCD, 1'b1, 3'd1, 1'b1, 1'b1);

        region(3'd2, 24'h008000, 24'h008000, 24'hFFFFFF, 24'h000000, 4'h1);
        commit();
        look("priority", 24'h008000, 24'h000000, 1'b1, 3'd0, 1'b0, 1'b0);
        look("miss", 24'h7E1234, 24'h7E1234, 1'b0, 3'd0, 1'b0, 1'b0);

        cfg_wr(3'd0, 3'd3, 24'h100000);
        chk("rewrite_pending", 32'(cfg_pending), 32'd1);
        look("old_base", 24'h018123, 24'h008123, 1'b1, 3'd0, 1'b0, 1'b0);

        // Commit and a flags write in the same cycle, with a lookup riding the commit edge.
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_field = 3'd4; cfg_data = 24'h00000B;
        cfg_commit = 1'b1;
        addr_valid = 1'b1; snes_addr = 24'h018123;
        @(negedge clk);
        cfg_we = 1'b0; cfg_commit = 1'b0;
        addr_valid = 1'b1; snes_addr = 24'h018123;
        @(negedge clk);
        addr_valid = 1'b0;
        chk("inflight_rom", 32'(rom_addr), 32'h008123);
        chk("inflight_wr", 32'(is_writable), 32'd0);
        chk("commit_pending", 32'(cfg_pending), 32'd0);
        @(negedge clk);
        chk("newbase_rom", 32'(rom_addr), 32'h108123);
        chk("newbase_wr", 32'(is_writable), 32'd1);
        chk("newbase_valid", 32'(out_valid), 32'd1);

        @(negedge clk);
        addr_valid = 1'b1; snes_addr = 24'h008000;
        @(negedge clk);
        snes_addr = 24'h790000;
        @(negedge clk);
        snes_addr = 24'h7E0000;
        chk("b2b0_valid", 32'(out_valid), 32'd1);
        chk("b2b0_rom", 32'(rom_addr), 32'h100000);
        chk("b2b0_idx", 32'(region_idx), 32'd0);
        @(negedge clk);
        addr_valid = 1'b0;
        chk("b2b1_valid", 32'(out_valid), 32'd1);
        chk("b2b1_rom", 32'(rom_addr), 32'hE10000);
        chk("b2b1_idx", 32'(region_idx), 32'd1);
        @(negedge clk);
        chk("b2b2_valid", 32'(out_valid), 32'd1);
        chk("b2b2_rom", 32'(rom_addr), 32'h7E0000);
        chk("b2b2_hit", 32'(rom_hit), 32'd0);
        @(negedge clk);
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_rom", 32'(rom_addr), 32'h7E0000);

        cfg_wr(3'd3, 3'd0, 24'h123456);
        @(negedge clk);
        addr_valid = 1'b1; snes_addr = 24'h008000;
        @(negedge clk);
        snes_addr = 24'h790000;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_rom", 32'(rom_addr), 32'd0);
        chk("arst_hit", 32'(rom_hit), 32'd0);
        chk("arst_idx", 32'(region_idx), 32'd0);
        chk("arst_pending", 32'(cfg_pending), 32'd0);
        @(negedge clk);
        addr_valid = 1'b0;
        rst_n = 1'b1;
        look("post_rst", 24'h008000, 24'h008000, 1'b0, 3'd0, 1'b0, 1'b0);

        @(negedge clk);
        en_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
